// File: rtl/mac_learn_table.sv
// mac_learn_table: small fully-associative IP-to-MAC cache.
// The receive path learns (IP, MAC) pairs; the transmit path looks up an IP
// and receives a registered {hit, MAC} result one cycle later.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on valid of the same channel. The result
// channel (mac_addr_*) holds all outputs stable while valid is high and
// mac_addr_rdy is low.
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef MAC_ADDR_W
`define MAC_ADDR_W 48
`endif

module mac_learn_table #(
    parameter int NUM_ENTRIES = 8,
    localparam int PTR_W = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [`IP_ADDR_W-1:0]  learn_ip,
    input  logic [`MAC_ADDR_W-1:0] learn_mac,
    input  logic                   learn_val,
    output logic                   learn_rdy,
    input  logic [`IP_ADDR_W-1:0]  ip_addr,
    input  logic                   ip_addr_val,
    output logic                   ip_addr_rdy,
    output logic [`MAC_ADDR_W-1:0] mac_addr,
    output logic                   mac_addr_val,
    output logic                   mac_addr_hit,
    input  logic                   mac_addr_rdy
);

    // Table state. IP/MAC storage is not reset; valid bits qualify it.
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [`IP_ADDR_W-1:0]  ip_tab  [NUM_ENTRIES];
    logic [`MAC_ADDR_W-1:0] mac_tab [NUM_ENTRIES];
    logic [PTR_W-1:0]       ptr_q;

    // Learn-side decode
    logic             learn_fire;
    logic             learn_hit;
    logic [PTR_W-1:0] learn_hit_idx;
    logic             free_any;
    logic [PTR_W-1:0] free_idx;
    logic             wr_en;
    logic             new_entry;
    logic             adv_ptr;
    logic [PTR_W-1:0] wr_idx;

    // Lookup-side decode
    logic                   lk_fire;
    logic                   lk_hit;
    logic [`MAC_ADDR_W-1:0] lk_mac;

    // Flush owns the table for its cycle, so learns are refused then.
    assign learn_rdy  = ~flush;
    assign learn_fire = learn_val & learn_rdy;

    // Find an existing entry for learn_ip and the lowest-index free slot.
    // Scanning downward lets the lowest matching index win.
    always_comb begin
        learn_hit     = 1'b0;
        learn_hit_idx = '0;
        free_any      = 1'b0;
        free_idx      = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (ip_tab[i] == learn_ip)) begin
                learn_hit     = 1'b1;
                learn_hit_idx = PTR_W'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = PTR_W'(i);
            end
        end
    end

    // Pick the learn target: refresh existing, fill free, else evict at pointer.
    // IP 0 is accepted but never stored.
    always_comb begin
        wr_en     = 1'b0;
        new_entry = 1'b0;
        adv_ptr   = 1'b0;
        wr_idx    = ptr_q;
        if (learn_fire && (learn_ip != '0) && !rst) begin
            wr_en = 1'b1;
            if (learn_hit) begin
                wr_idx = learn_hit_idx;
            end else if (free_any) begin
                wr_idx    = free_idx;
                new_entry = 1'b1;
            end else begin
                wr_idx    = ptr_q;
                new_entry = 1'b1;
                adv_ptr   = 1'b1;
            end
        end
    end

    // Entry storage write; the IP field only changes when a new entry is made.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mac_tab[wr_idx] <= learn_mac;
            if (new_entry) begin
                ip_tab[wr_idx] <= learn_ip;
            end
        end
    end

    // Valid bits and round-robin pointer; reset and flush both empty the table.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (wr_en && new_entry) begin
                valid_q[wr_idx] <= 1'b1;
            end
            if (adv_ptr) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    // Associative compare against pre-edge contents; at most one entry matches,
    // so OR-combining the MACs selects the matching one. IP 0 never hits.
    always_comb begin
        lk_hit = 1'b0;
        lk_mac = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && (ip_tab[i] == ip_addr) && (ip_addr != '0)) begin
                lk_hit = 1'b1;
                lk_mac = lk_mac | mac_tab[i];
            end
        end
    end

    assign ip_addr_rdy = ~mac_addr_val | mac_addr_rdy;
    assign lk_fire     = ip_addr_val & ip_addr_rdy;

    // Single-entry result register: load on accept, clear on consume, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_addr_val <= 1'b0;
            mac_addr_hit <= 1'b0;
            mac_addr     <= '0;
        end else if (lk_fire) begin
            mac_addr_val <= 1'b1;
            mac_addr_hit <= lk_hit;
            mac_addr     <= lk_mac;
        end else if (mac_addr_rdy) begin
            mac_addr_val <= 1'b0;
            mac_addr_hit <= 1'b0;
            mac_addr     <= '0;
        end
    end

endmodule
